// File: rtl/axis_frame_source.sv
// rtl/axis_frame_source.sv - AXI4-Stream frame source reading words from a sync-read memory
module axis_frame_source #(
  parameter int TBITS  = 64,
  parameter int TBYTE  = 8,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  frame_len,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  tx_count,
  output logic [1:0]        current_state,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [TBITS-1:0]  mem_rdata,
  output logic              M_AXIS_TVALID,
  input  logic              M_AXIS_TREADY,
  output logic [TBITS-1:0]  M_AXIS_TDATA,
  output logic [TBYTE-1:0]  M_AXIS_TKEEP,
  output logic              M_AXIS_TLAST
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issue_cnt;
  logic [LEN_W-1:0]  tx_cnt;
  logic              inflight;
  logic              inflight_last;

  logic [TBITS-1:0]  fifo_data [4];
  logic              fifo_last [4];
  logic [1:0]        wr_ptr;
  logic [1:0]        rd_ptr;
  logic [2:0]        fifo_count;

  logic              issue;
  logic              push;
  logic              pop;
  logic              tvalid;
  logic [ADDR_W-1:0] issue_lo;

  // Credit counts only registered occupancy plus the read in flight, so
  // TREADY never reaches the memory enable.
  assign tvalid   = (fifo_count != 3'd0);
  assign pop      = tvalid && M_AXIS_TREADY;
  assign push     = inflight;
  assign issue    = (state == S_FETCH) && (issue_cnt < len_q) &&
                    ((fifo_count + {2'b00, inflight}) < 3'd4);
  assign issue_lo = issue_cnt[ADDR_W-1:0];

  assign mem_en        = issue;
  assign mem_addr      = issue ? (base_q + issue_lo) : '0;
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);
  assign current_state = state;
  assign tx_count      = tx_cnt;

  assign M_AXIS_TVALID = tvalid;
  assign M_AXIS_TDATA  = tvalid ? fifo_data[rd_ptr] : '0;
  assign M_AXIS_TLAST  = tvalid ? fifo_last[rd_ptr] : 1'b0;
  assign M_AXIS_TKEEP  = tvalid ? '1 : '0;

  always_ff @(posedge aclk) begin
    if (push) begin
      fifo_data[wr_ptr] <= mem_rdata;
      fifo_last[wr_ptr] <= inflight_last;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state         <= S_IDLE;
      base_q        <= '0;
      len_q         <= '0;
      issue_cnt     <= '0;
      tx_cnt        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_last <= (issue_cnt == len_q - LEN_W'(1));
        issue_cnt     <= issue_cnt + LEN_W'(1);
      end
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
        tx_cnt <= tx_cnt + LEN_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase

      case (state)
        S_IDLE: begin
          if (start) begin
            base_q    <= base_addr;
            len_q     <= frame_len;
            issue_cnt <= '0;
            tx_cnt    <= '0;
            inflight  <= 1'b0;
            state     <= (frame_len != '0) ? S_FETCH : S_DONE;
          end
        end
        S_FETCH: begin
          if (issue && (issue_cnt == len_q - LEN_W'(1))) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if ((tx_cnt == len_q) && (fifo_count == 3'd0)) state <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
